sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Upstream neighbour of the Nano 20k SDRAM controller. Multiplexes a CPU port, a video read port and a periodic refresh onto the controller's single cs/we/addr/ds/din/refresh/dout interface.
- Generates the cs rising edge the controller needs for each access, holds all request fields stable for a full slot, captures read data at a fixed latency and returns it with a one-cycle ack.
- Priority order: refresh > video > CPU.

Parameters:
- SLOT_LEN, 8: mem_cs high time in clk cycles per slot; covers the controller's full 8-state cycle.
- DATA_LAT, 6: clk edge after grant at which mem_dout is captured.
- REFRESH_CYCLES, 240: clk cycles between refresh requests (7.8 us at 32 MHz, with margin).

Ports:
- clk  in  1  system clock, 32 MHz, same clock as the SDRAM controller
- reset_n  in  1  asynchronous active-low reset
- ram_ready  in  1  controller initialisation done
- cpu_req  in  1  CPU request; held with fields stable until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  22  word address
- cpu_ds  in  2  upper/lower byte strobes, active low
- cpu_din  in  16  write data
- cpu_dout  out  16  read data
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video read request; held until vid_ack
- vid_addr  in  22  word address
- vid_dout  out  16  read data
- vid_ack  out  1  one-cycle completion pulse
- mem_cs, mem_we, mem_refresh  out  1 each  to controller cs/we/refresh
- mem_addr  out  22  to controller addr
- mem_ds  out  2  to controller ds
- mem_din  out  16  to controller din
- mem_dout  in  16  from controller dout

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0, including mem_ds = 2'b00.
  - FSM goes to IDLE; slot counter, refresh counter and refresh_pending are cleared.
  - Asserting reset mid-slot aborts the slot, drops mem_cs immediately and generates no ack.
- ram_ready low:
  - No grants are issued.
  - Refresh counter is held at 0 and refresh_pending is cleared.
- Refresh counter:
  - Counts clk while ram_ready is high.
  - On reaching REFRESH_CYCLES-1 it wraps to 0 and sets refresh_pending.
  - refresh_pending clears when a refresh slot is granted. A second wrap while pending does not queue a second refresh.
- FSM states: IDLE, SLOT, GAP.
- IDLE, grant on the same clk edge the request is seen:
  - If refresh_pending: mem_refresh=1, mem_we=0, mem_cs=1.
  - Else if vid_req: mem_addr=vid_addr, mem_we=0, mem_ds=00, mem_cs=1.
  - Else if cpu_req: mem_addr, mem_we, mem_ds and mem_din are loaded from the cpu_* inputs, then mem_cs=1.
  - Go to SLOT with slot counter = 0.
- SLOT:
  - Counter increments each edge. mem_* fields are frozen for the whole slot.
  - At counter edge DATA_LAT on a non-refresh read, mem_dout is registered into the granted client's dout.
  - On the next cycle the granted client's ack is high for exactly one cycle. For CPU writes the ack is also issued at this point; cpu_dout is left unchanged on writes.
  - Refresh slots produce no ack.
  - At counter edge SLOT_LEN: mem_cs=0, mem_refresh=0, go to GAP.
- GAP:
  - One cycle with mem_cs low so the controller sees a fresh rising edge. Then return to IDLE.
  - Minimum request-to-request spacing is SLOT_LEN+1 = 9 cycles.
- Request handling:
  - A client must drop its req in the cycle after its ack, or the arbiter issues another access.
  - A req deasserted before grant is ignored. A req deasserted after grant does not stop the slot; the ack still pulses.
- Simultaneous events:
  - All three requests pending in IDLE: refresh slot, then video, then CPU.
  - A CPU request may wait indefinitely under continuous video requests; this is accepted, since the video load is bounded by the display timing.
- mem_dout is only valid at the capture edge; other values are not forwarded.

Test Plan:
- Reset release with ram_ready low for 50 cycles, cpu_req high -> mem_cs stays 0, no ack. Raise ram_ready -> mem_cs rises on the next edge with mem_addr = cpu_addr.
- CPU read of addr 22'h012345, model returns 16'hBEEF at edge 6 -> cpu_dout = 16'hBEEF, cpu_ack high exactly at cycle 7, mem_cs high exactly 8 cycles, then low for 1 cycle.
- CPU write: addr 22'h000010, din 16'hA55A, ds 2'b10 -> mem_we=1, mem_ds=10, mem_din=A55A stable for 8 cycles; cpu_ack at cycle 7; cpu_dout unchanged.
- vid_req and cpu_req raised on the same edge -> video slot first with vid_ack; CPU slot starts 9 cycles after the video grant.
- Idle run of 240 cycles -> one slot with mem_refresh=1, mem_cs=1 for 8 cycles, no acks. With refresh_pending set and vid_req high together -> refresh slot precedes the video slot.
- Assert reset_n low at cycle 3 of a CPU read -> mem_cs drops asynchronously, no cpu_ack. After release and re-request, the read completes normally.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: time-slot arbiter in front of the Nano 20k SDRAM controller.
// Shares one cs/we/addr/ds/din/refresh/dout port between a periodic refresh,
// a video read client and a CPU client (priority in that order). Each access
// is a fixed slot of SLOT_LEN cycles with mem_cs high, followed by one cycle
// with mem_cs low so the controller sees a fresh cs rising edge.
module sdram_arbiter #(
  parameter int SLOT_LEN       = 8,
  parameter int DATA_LAT       = 6,
  parameter int REFRESH_CYCLES = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ram_ready,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  output logic [15:0] vid_dout,
  output logic        vid_ack,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  localparam int CW = $clog2(SLOT_LEN + 1);
  localparam int RW = $clog2(REFRESH_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLOT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] OWN_REF = 2'd0;
  localparam logic [1:0] OWN_VID = 2'd1;
  localparam logic [1:0] OWN_CPU = 2'd2;

  logic [1:0]    state;
  logic [1:0]    owner;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [RW-1:0] ref_cnt;
  logic          refresh_pending;

  logic can_grant;
  logic grant_ref;
  logic grant_vid;
  logic grant_cpu;

  // The GAP cycle may grant too: mem_cs is already low during it, so a new
  // grant at its closing edge keeps request-to-request spacing at SLOT_LEN+1.
  assign can_grant = ram_ready && (state == ST_IDLE || state == ST_GAP);
  assign grant_ref = can_grant && refresh_pending;
  assign grant_vid = can_grant && !refresh_pending && vid_req;
  assign grant_cpu = can_grant && !refresh_pending && !vid_req && cpu_req;
  assign cnt_next  = cnt + 1'b1;

  // Refresh interval timer; a wrap outranks a same-edge grant so no interval is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
    end else if (!ram_ready) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
    end else if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      if (grant_ref) refresh_pending <= 1'b0;
    end
  end

  // Slot FSM: grant, hold the request fields, capture read data, pulse ack, close slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_REF;
      cnt         <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr    <= '0;
      mem_ds      <= 2'b00;
      mem_din     <= '0;
      cpu_dout    <= '0;
      vid_dout    <= '0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      case (state)
        ST_IDLE, ST_GAP: begin
          cnt <= '0;
          if (grant_ref) begin
            owner       <= OWN_REF;
            mem_refresh <= 1'b1;
            mem_we      <= 1'b0;
            mem_cs      <= 1'b1;
            state       <= ST_SLOT;
          end else if (grant_vid) begin
            owner    <= OWN_VID;
            mem_addr <= vid_addr;
            mem_we   <= 1'b0;
            mem_ds   <= 2'b00;
            mem_cs   <= 1'b1;
            state    <= ST_SLOT;
          end else if (grant_cpu) begin
            owner    <= OWN_CPU;
            mem_addr <= cpu_addr;
            mem_we   <= cpu_we;
            mem_ds   <= cpu_ds;
            mem_din  <= cpu_din;
            mem_cs   <= 1'b1;
            state    <= ST_SLOT;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SLOT: begin
          cnt <= cnt_next;
          // mem_dout is only meaningful on this one edge of the slot.
          if (cnt_next == CW'(DATA_LAT) && !mem_we) begin
            if (owner == OWN_VID) vid_dout <= mem_dout;
            if (owner == OWN_CPU) cpu_dout <= mem_dout;
          end
          if (cnt_next == CW'(DATA_LAT + 1)) begin
            vid_ack <= (owner == OWN_VID);
            cpu_ack <= (owner == OWN_CPU);
          end
          if (cnt_next == CW'(SLOT_LEN)) begin
            mem_cs      <= 1'b0;
            mem_refresh <= 1'b0;
            state       <= ST_GAP;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus with a scoreboard. The driver pushes the
// expected grants and acks into a queue; a monitor on the falling edge pops an
// entry whenever mem_cs rises or an ack pulses and compares it, and also plays
// the SDRAM controller by presenting read data only in the capture cycle.
module tb_sdram_arbiter;

  localparam int SLOT_LEN = 8;
  localparam int DATA_LAT = 6;

  localparam logic [2:0] K_REF     = 3'd0;
  localparam logic [2:0] K_VID     = 3'd1;
  localparam logic [2:0] K_CPU     = 3'd2;
  localparam logic [2:0] K_ACK_CPU = 3'd3;
  localparam logic [2:0] K_ACK_VID = 3'd4;

  typedef struct {
    logic [2:0]  kind;
    logic [21:0] addr;
    logic        we;
    logic [1:0]  ds;
    logic [15:0] din;
    logic [15:0] data;
    int          at;    // required ready_edges value at grant, -1 = any
    int          gap;   // required cycles since previous grant, -1 = any
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ram_ready;
  logic        cpu_req, cpu_we;
  logic [21:0] cpu_addr;
  logic [1:0]  cpu_ds;
  logic [15:0] cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        vid_req;
  logic [21:0] vid_addr;
  logic [15:0] vid_dout;
  logic        vid_ack;
  logic        mem_cs, mem_we, mem_refresh;
  logic [21:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din, mem_dout;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   ready_edges;

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .ram_ready(ram_ready),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges seen with ram_ready high since reset; mirrors the refresh timebase.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_edges <= 0;
    else if (ram_ready) ready_edges <= ready_edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got an unmatched or missing event, expected the queued one", name);
  endtask

  task automatic push(input logic [2:0] kind, input logic [21:0] addr, input logic we,
                      input logic [1:0] ds, input logic [15:0] din, input logic [15:0] data,
                      input int at, input int gap);
    exp_t e;
    e.kind = kind; e.addr = addr; e.we = we; e.ds = ds;
    e.din = din; e.data = data; e.at = at; e.gap = gap;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] model_rd(input logic [21:0] a);
    case (a)
      22'h012345: return 16'hBEEF;
      22'h200100: return 16'h1234;
      22'h3ABCDE: return 16'hCAFE;
      22'h1F0F0F: return 16'h7E57;
      default:    return 16'h0BAD;
    endcase
  endfunction

  // Monitor and controller model: everything sampled on the falling edge.
  initial begin : monitor
    exp_t        e;
    logic        prev_cs = 1'b0;
    logic        stable  = 1'b1;
    int          age     = 0;
    int          high    = 0;
    int          last_grant = 0;
    logic [21:0] s_addr;
    logic        s_we, s_ref;
    logic [1:0]  s_ds;
    logic [15:0] s_din;
    mem_dout = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_cs  = 1'b0;
        mem_dout = 16'hDEAD;
      end else begin
        if (mem_cs && !prev_cs) begin
          age = 0; high = 1; stable = 1'b1;
          s_addr = mem_addr; s_we = mem_we; s_ref = mem_refresh; s_ds = mem_ds; s_din = mem_din;
          if (exp_q.size() == 0) fail("unexpected_grant");
          else begin
            e = exp_q.pop_front();
            if (e.kind > K_CPU) fail("grant_before_ack");
            else if (e.kind == K_REF) begin
              check("ref_flag", 32'(mem_refresh), 32'd1);
              check("ref_we", 32'(mem_we), 32'd0);
            end else begin
              check("grant_refresh_low", 32'(mem_refresh), 32'd0);
              check("grant_addr", 32'(mem_addr), 32'(e.addr));
              check("grant_we", 32'(mem_we), 32'(e.we));
              check("grant_ds", 32'(mem_ds), 32'(e.ds));
              if (e.we) check("grant_din", 32'(mem_din), 32'(e.din));
            end
            if (e.at >= 0) check("grant_edge", 32'(ready_edges), 32'(e.at));
            if (e.gap >= 0) check("grant_spacing", 32'(cyc - last_grant), 32'(e.gap));
          end
          last_grant = cyc;
        end else if (mem_cs) begin
          age++; high++;
          if (mem_addr !== s_addr || mem_we !== s_we || mem_refresh !== s_ref ||
              mem_ds !== s_ds || mem_din !== s_din) stable = 1'b0;
        end else if (prev_cs) begin
          check("cs_high_cycles", 32'(high), 32'(SLOT_LEN));
          check("fields_stable", 32'(stable), 32'd1);
          check("refresh_dropped", 32'(mem_refresh), 32'd0);
        end

        if (cpu_ack && vid_ack) fail("double_ack");
        else if (cpu_ack || vid_ack) begin
          if (exp_q.size() == 0) fail("unexpected_ack");
          else begin
            e = exp_q.pop_front();
            check("ack_client", 32'(cpu_ack ? K_ACK_CPU : K_ACK_VID), 32'(e.kind));
            check("ack_data", 32'(cpu_ack ? cpu_dout : vid_dout), 32'(e.data));
            check("ack_latency", 32'(age), 32'(DATA_LAT + 1));
          end
        end

        mem_dout = (mem_cs && !mem_refresh && age == DATA_LAT - 1) ? model_rd(mem_addr) : 16'hDEAD;
        prev_cs  = mem_cs;
      end
    end
  end

  task automatic wait_ack(input bit vid, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (vid ? vid_ack : cpu_ack) seen = 1'b1;
    end
    if (!seen) fail(vid ? "vid_ack_timeout" : "cpu_ack_timeout");
  endtask

  task automatic cpu_issue(input logic we, input logic [21:0] addr, input logic [1:0] ds,
                           input logic [15:0] din);
    cpu_we = we; cpu_addr = addr; cpu_ds = ds; cpu_din = din; cpu_req = 1'b1;
  endtask

  initial begin : driver
    bit cs_seen;
    bit hit;
    reset_n = 1'b0; ram_ready = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_ds = 2'b11; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_refresh", 32'(mem_refresh), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_ds", 32'(mem_ds), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_vid_ack", 32'(vid_ack), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_vid_dout", 32'(vid_dout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ram_ready low: request is held off, then granted on the first ready edge.
    @(posedge clk); #1;
    cpu_issue(1'b0, 22'h012345, 2'b00, 16'h0000);
    cs_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (mem_cs) cs_seen = 1'b1;
    end
    check("ready_low_no_cs", 32'(cs_seen), 32'd0);
    push(K_CPU, 22'h012345, 1'b0, 2'b00, 16'h0000, 16'h0000, 1, -1);
    push(K_ACK_CPU, '0, 1'b0, 2'b00, 16'h0000, 16'hBEEF, -1, -1);
    @(posedge clk); #1;
    ram_ready = 1'b1;
    wait_ack(1'b0, 30);
    cpu_req = 1'b0;

    // CPU write: read data register stays at the last read value.
    @(posedge clk); #1;
    cpu_issue(1'b1, 22'h000010, 2'b10, 16'hA55A);
    push(K_CPU, 22'h000010, 1'b1, 2'b10, 16'hA55A, 16'h0000, -1, -1);
    push(K_ACK_CPU, '0, 1'b0, 2'b00, 16'h0000, 16'hBEEF, -1, -1);
    wait_ack(1'b0, 30);
    cpu_req = 1'b0;

    // Video and CPU on the same edge: video first, CPU SLOT_LEN+1 cycles later.
    @(posedge clk); #1;
    vid_addr = 22'h200100; vid_req = 1'b1;
    cpu_issue(1'b0, 22'h3ABCDE, 2'b00, 16'h0000);
    push(K_VID, 22'h200100, 1'b0, 2'b00, 16'h0000, 16'h0000, -1, -1);
    push(K_ACK_VID, '0, 1'b0, 2'b00, 16'h0000, 16'h1234, -1, -1);
    push(K_CPU, 22'h3ABCDE, 1'b0, 2'b00, 16'h0000, 16'h0000, -1, SLOT_LEN + 1);
    push(K_ACK_CPU, '0, 1'b0, 2'b00, 16'h0000, 16'hCAFE, -1, -1);
    wait_ack(1'b1, 30);
    vid_req = 1'b0;
    wait_ack(1'b0, 30);
    cpu_req = 1'b0;

    // Idle: first refresh slot lands one edge after the 240th ready edge.
    push(K_REF, '0, 1'b0, 2'b00, 16'h0000, 16'h0000, 241, -1);
    for (int i = 0; i < 400 && ready_edges < 260; i++) @(negedge clk);

    // Refresh pending together with a video request: refresh goes first.
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge clk); #1;
      if (ready_edges == 480) hit = 1'b1;
    end
    if (!hit) fail("refresh_window_timeout");
    vid_addr = 22'h1F0F0F; vid_req = 1'b1;
    push(K_REF, '0, 1'b0, 2'b00, 16'h0000, 16'h0000, 481, -1);
    push(K_VID, 22'h1F0F0F, 1'b0, 2'b00, 16'h0000, 16'h0000, -1, SLOT_LEN + 1);
    push(K_ACK_VID, '0, 1'b0, 2'b00, 16'h0000, 16'h7E57, -1, -1);
    wait_ack(1'b1, 40);
    vid_req = 1'b0;

    // Reset in cycle 3 of a CPU read: cs drops at once, no ack ever arrives.
    repeat (3) @(posedge clk);
    #1;
    cpu_issue(1'b0, 22'h012345, 2'b00, 16'h0000);
    push(K_CPU, 22'h012345, 1'b0, 2'b00, 16'h0000, 16'h0000, -1, -1);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_cs_async", 32'(mem_cs), 32'd0);
    check("abort_no_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_cpu_dout", 32'(cpu_dout), 32'd0);
    reset_n = 1'b1;

    // Re-request after reset completes normally.
    @(posedge clk); #1;
    cpu_issue(1'b0, 22'h012345, 2'b00, 16'h0000);
    push(K_CPU, 22'h012345, 1'b0, 2'b00, 16'h0000, 16'h0000, -1, -1);
    push(K_ACK_CPU, '0, 1'b0, 2'b00, 16'h0000, 16'hBEEF, -1, -1);
    wait_ack(1'b0, 30);
    cpu_req = 1'b0;

    repeat (12) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
